// File: rtl/reg_file_pkg.sv
// Shared types and default parameters for the multi-port register file.
package reg_file_pkg;

   localparam int unsigned DEF_DATA_W  = 32;
   localparam int unsigned DEF_ADDR_W  = 6;
   localparam int unsigned DEF_LS_IDX  = 61;
   localparam int unsigned DEF_QUO_IDX = 62;
   localparam int unsigned DEF_OUT_IDX = 63;
   localparam int unsigned DEF_DBG_IDX = 15;

   typedef enum logic [1:0] {
      REGULAR = 2'b00,
      MULT    = 2'b01,
      DIV     = 2'b10,
      RSVD    = 2'b11
   } wr_mode_t;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } rf_state_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/write-back facing bus of the register file.
interface reg_file_mp_if
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
);
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;
   logic              wr_en;
   wr_mode_t          wr_mode;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] wr_data_hi;
   logic [DATA_W-1:0] out_data;
   logic [DATA_W-1:0] dbg_data;
   logic              busy;
   logic              wr_err;

   modport master (
      output rd_addr_a, rd_addr_b, wr_en, wr_mode, wr_addr, wr_data, wr_data_hi,
      input  rd_data_a, rd_data_b, out_data, dbg_data, busy, wr_err
   );

   modport slave (
      input  rd_addr_a, rd_addr_b, wr_en, wr_mode, wr_addr, wr_data, wr_data_hi,
      output rd_data_a, rd_data_b, out_data, dbg_data, busy, wr_err
   );
endinterface

// File: rtl/reg_file_clear_seq.sv
// Post-reset sweep: walks the address space from the top down to zero.
module reg_file_clear_seq
   import reg_file_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   output logic              busy,
   output logic              clr_en,
   output logic [ADDR_W-1:0] clr_addr
);
   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(DEPTH - 1);

   rf_state_t state;

   // Sweep FSM; reset restarts the sweep from the top address.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= CLEAR;
         clr_addr <= TOP_ADDR;
         busy     <= 1'b1;
         clr_en   <= 1'b1;
      end else begin
         case (state)
            CLEAR: begin
               if (clr_addr == '0) begin
                  state  <= READY;
                  busy   <= 1'b0;
                  clr_en <= 1'b0;
               end else begin
                  clr_addr <= clr_addr - ADDR_W'(1);
               end
            end
            READY: begin
               busy   <= 1'b0;
               clr_en <= 1'b0;
            end
            default: begin
               state <= CLEAR;
               busy  <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: rtl/reg_file_mp.sv
// Register file: two write-first registered read ports, one write port with
// MULT/DIV secondary write, and a post-reset clearing sweep.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned LS_IDX  = DEF_LS_IDX,
   parameter int unsigned QUO_IDX = DEF_QUO_IDX,
   parameter int unsigned OUT_IDX = DEF_OUT_IDX,
   parameter int unsigned DBG_IDX = DEF_DBG_IDX
) (
   input  logic         clk,
   input  logic         reset,
   reg_file_mp_if.slave bus
);
   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LS_A  = ADDR_W'(LS_IDX);
   localparam logic [ADDR_W-1:0] QUO_A = ADDR_W'(QUO_IDX);
   localparam logic [ADDR_W-1:0] OUT_A = ADDR_W'(OUT_IDX);
   localparam logic [ADDR_W-1:0] DBG_A = ADDR_W'(DBG_IDX);

   logic [DATA_W-1:0] registers [DEPTH];

   logic              busy;
   logic              clr_en;
   logic [ADDR_W-1:0] clr_addr;
   logic              pri_we;
   logic              sec_we;
   logic [ADDR_W-1:0] sec_addr;
   logic              err;
   logic [DATA_W-1:0] nxt_a;
   logic [DATA_W-1:0] nxt_b;

   reg_file_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
      .clk      (clk),
      .reset    (reset),
      .busy     (busy),
      .clr_en   (clr_en),
      .clr_addr (clr_addr)
   );

   // Write decode: primary/secondary enables and rejection flag.
   always_comb begin
      pri_we   = 1'b0;
      sec_we   = 1'b0;
      sec_addr = QUO_A;
      err      = 1'b0;
      if (!reset && bus.wr_en) begin
         if (busy) begin
            err = 1'b1;
         end else begin
            case (bus.wr_mode)
               REGULAR: pri_we = 1'b1;
               MULT: begin
                  pri_we   = 1'b1;
                  sec_we   = 1'b1;
                  sec_addr = LS_A;
               end
               DIV: begin
                  pri_we   = 1'b1;
                  sec_we   = 1'b1;
                  sec_addr = QUO_A;
               end
               default: err = 1'b1;
            endcase
         end
      end
   end

   // Write-first bypass; secondary data overrides on address collision.
   always_comb begin
      nxt_a = registers[bus.rd_addr_a];
      if (pri_we && bus.rd_addr_a == bus.wr_addr) nxt_a = bus.wr_data;
      if (sec_we && bus.rd_addr_a == sec_addr)    nxt_a = bus.wr_data_hi;
      nxt_b = registers[bus.rd_addr_b];
      if (pri_we && bus.rd_addr_b == bus.wr_addr) nxt_b = bus.wr_data;
      if (sec_we && bus.rd_addr_b == sec_addr)    nxt_b = bus.wr_data_hi;
   end

   // Array update: sweep clears, else primary then secondary (secondary wins).
   always_ff @(posedge clk) begin
      if (clr_en) begin
         registers[clr_addr] <= '0;
      end else begin
         if (pri_we) registers[bus.wr_addr] <= bus.wr_data;
         if (sec_we) registers[sec_addr]    <= bus.wr_data_hi;
      end
   end

   // Registered read data and error pulse.
   always_ff @(posedge clk) begin
      if (reset || busy) begin
         bus.rd_data_a <= '0;
         bus.rd_data_b <= '0;
      end else begin
         bus.rd_data_a <= nxt_a;
         bus.rd_data_b <= nxt_b;
      end
      if (reset) bus.wr_err <= 1'b0;
      else       bus.wr_err <= err;
   end

   assign bus.busy     = busy;
   assign bus.out_data = busy ? '0 : registers[OUT_A];
   assign bus.dbg_data = busy ? '0 : registers[DBG_A];
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised successor to the processor's 64×32 register file: two registered read ports, one write port with mode-dependent dual write for multiply/divide results, and a hardware clear sequencer that zeroes every register after reset. It sits between decode (read addresses) and write-back (write address/data). Unlike the previous generation, all activity is on `posedge clk`, both read ports share identical semantics, and same-cycle read-after-write is bypassed.

## Interface
Parameters:
- `DATA_W`, 32: register width.
- `ADDR_W`, 6: address width; `DEPTH = 2**ADDR_W`.
- `LS_IDX`, 61: secondary target for MULT high word.
- `QUO_IDX`, 62: secondary target for DIV quotient.
- `OUT_IDX`, 63: register exported on `out_data`.
- `DBG_IDX`, 15: register exported on `dbg_data`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `rd_addr_a`, `rd_addr_b`  in  ADDR_W  read addresses.
- `rd_data_a`, `rd_data_b`  out  DATA_W  registered read data.
- `wr_en`  in  1  write request.
- `wr_mode`  in  2  00 REGULAR, 01 MULT, 10 DIV, 11 reserved.
- `wr_addr`  in  ADDR_W  primary write address.
- `wr_data`  in  DATA_W  primary write data.
- `wr_data_hi`  in  DATA_W  secondary write data (MULT/DIV).
- `out_data`, `dbg_data`  out  DATA_W  live view of `OUT_IDX` and `DBG_IDX`.
- `busy`  out  1  clear sweep in progress.
- `wr_err`  out  1  one-cycle pulse on rejected write.

## Operation
- FSM states CLEAR and READY. `reset` at any edge → CLEAR, sweep counter = DEPTH-1, `busy`=1; this restarts any sweep in progress.
- CLEAR: each edge writes 0 to `registers[cnt]` and decrements `cnt`; the edge that clears index 0 → READY, `busy`=0.
- In CLEAR, `wr_en` is ignored; `wr_err` pulses if `wr_en`=1. `rd_data_*` load 0. `out_data`/`dbg_data` are forced to 0.
- In READY with `wr_en`=1:
  - REGULAR: `wr_data`→`wr_addr`.
  - MULT: `wr_data`→`wr_addr` and `wr_data_hi`→`LS_IDX`.
  - DIV: `wr_data`→`wr_addr` and `wr_data_hi`→`QUO_IDX`.
  - Mode 11: no write, `wr_err` pulses.
- Collision: if `wr_addr` equals the secondary index in MULT/DIV, `wr_data_hi` wins.
- Reads are write-first. If a read address matches any register written on the same edge, `rd_data` takes the new value, with the secondary-wins rule applied.
- `out_data`/`dbg_data` are combinational from the array (gated by `busy`) and reflect writes the cycle after the write edge.

## Timing
- Reset values (after the reset edge): `rd_data_a`/`rd_data_b`=0, `busy`=1, `wr_err`=0, `out_data`/`dbg_data`=0.
- Reset sampled high at edge k → clears on edges k+1 … k+DEPTH (64 for defaults) → `busy`=0 after edge k+DEPTH. The first write is accepted at edge k+DEPTH+1.
- Holding `reset` high keeps the counter at DEPTH-1 and `busy`=1.
- Read latency: 1 cycle; the address sampled at edge n yields data valid after edge n.
- Write latency: visible on read ports at the same edge (bypass) and on `out_data` after that edge.
- `wr_err` asserts for exactly one cycle per offending edge.

## Structure
- Shared package `reg_file_pkg`: `wr_mode_t` enum (REGULAR, MULT, DIV, RSVD), `rf_state_t` enum (CLEAR, READY), default index constants LS/QUO/OUT.
- One sub-module, `reg_file_clear_seq`: FSM plus down-counter, outputs `busy`, `clr_en`, `clr_addr`.
- The top module holds the array, write decode, bypass muxes and output registers.

## Test plan
- Reset for 1 cycle with random prior array contents → `busy`=1 for 64 cycles. After that, reading every address gives 0, and `out_data`=0 throughout.
- REGULAR write of 0xDEADBEEF to r5 with `rd_addr_a`=5 on the same edge → `rd_data_a`=0xDEADBEEF after that edge. Next cycle `rd_data_b` at r5 reads the same.
- MULT, `wr_addr`=3, `wr_data`=0x1, `wr_data_hi`=0x2 → r3=0x1, r61=0x2. Then DIV with `wr_addr`=62, `wr_data`=0xA, `wr_data_hi`=0xB → r62=0xB (secondary wins).
- REGULAR write of 0x55 to r63 → `out_data`=0x55 after the edge. Write 0x77 to r15 → `dbg_data`=0x77.
- `wr_mode`=11 with `wr_en`=1 → no register changes, `wr_err`=1 for one cycle. Write attempt while `busy` → ignored, `wr_err`=1.
- Reset re-asserted at sweep cycle 30 → the sweep restarts and `busy` stays high 64 further cycles after the last reset edge.
